zorro_dma_burst_master: RTL

ZORRO_DMA_BURST_MASTER -- requirements
Module: zorro_dma_burst_master

---
 rtl/zorro_dma_burst_master_if.sv | 33 +++
 rtl/zorro_dma_burst_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/zorro_dma_burst_master_if.sv
// Zorro III DMA burst master signal bundle: transfer request/status plus bus strobes.
// The master modport is the DMA engine; the slave modport is the requester/bus side.
interface zorro_dma_burst_master_if #(
    parameter int CNT_W = 8
);
    logic             BMASTER;
    logic             START;
    logic             READ;
    logic [31:0]      ADDR;
    logic [3:0]       BYTE_EN;
    logic [CNT_W-1:0] BEATS;
    logic             ZORRO_DTACK_n;
    logic             ZORRO_BERR_n;
    logic [31:0]      DMA_ADDR;
    logic             DMA_FCS_n;
    logic [3:0]       DMA_DS_n;
    logic             DMA_DOE;
    logic             SCSI_STERM_n;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [CNT_W-1:0] BEAT_CNT;

    modport master (
        input  BMASTER, START, READ, ADDR, BYTE_EN, BEATS, ZORRO_DTACK_n, ZORRO_BERR_n,
        output DMA_ADDR, DMA_FCS_n, DMA_DS_n, DMA_DOE, SCSI_STERM_n, BUSY, DONE, ERR, BEAT_CNT
    );

    modport slave (
        output BMASTER, START, READ, ADDR, BYTE_EN, BEATS, ZORRO_DTACK_n, ZORRO_BERR_n,
        input  DMA_ADDR, DMA_FCS_n, DMA_DS_n, DMA_DOE, SCSI_STERM_n, BUSY, DONE, ERR, BEAT_CNT
    );
endinterface

// File: rtl/zorro_dma_burst_master.sv
// Zorro III DMA burst master: runs up to MAX_BEATS longword beats per START while granted.
// Optional DTACK watchdog enabled by defining ZORRO_DMA_TIMEOUT_EN.
module zorro_dma_burst_master #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                             CLK,
    input  logic                             RESET,
    zorro_dma_burst_master_if.master         bus
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, TERM, ABORT} state_t;

    localparam logic [CNT_W-1:0] MAX_BEATS_C = CNT_W'(MAX_BEATS);

    if (MAX_BEATS < 1 || MAX_BEATS > 255 || MAX_BEATS >= (1 << CNT_W) || TIMEOUT < 1) begin : g_param_check
        $error("zorro_dma_burst_master: illegal MAX_BEATS/CNT_W/TIMEOUT");
    end

    state_t           state;
    logic             rd_q;
    logic [3:0]       lanes_q;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [31:0]      addr_q;
    logic             fcs_n_q;
    logic [3:0]       ds_n_q;
    logic             sterm_n_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [CNT_W-1:0] beats_clamped;
    logic [CNT_W-1:0] beat_next;
    logic             more_beats;
    logic             to_expire;

    always_comb begin
        beats_clamped = bus.BEATS;
        if (bus.BEATS == '0) begin
            beats_clamped = CNT_W'(1);
        end else if (bus.BEATS > MAX_BEATS_C) begin
            beats_clamped = MAX_BEATS_C;
        end
    end

    assign beat_next  = beat_cnt_q + CNT_W'(1);
    assign more_beats = beat_cnt_q < total_q;

`ifdef ZORRO_DMA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign to_expire = (to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT);

    // Counts DATA cycles that saw neither DTACK nor BERR; cleared while in ADDR so it starts at 0 on DATA entry.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt_q <= '0;
        end else if (state == ADDR) begin
            to_cnt_q <= '0;
        end else if (state == DATA && bus.ZORRO_DTACK_n && bus.ZORRO_BERR_n) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // Outputs are registered alongside the state so strobes always match the cycle's state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            rd_q       <= 1'b0;
            lanes_q    <= 4'hF;
            total_q    <= '0;
            beat_cnt_q <= '0;
            addr_q     <= 32'h0;
            fcs_n_q    <= 1'b1;
            ds_n_q     <= 4'hF;
            sterm_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sterm_n_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.START && bus.BMASTER) begin
                        state      <= ADDR;
                        rd_q       <= bus.READ;
                        lanes_q    <= bus.BYTE_EN;
                        total_q    <= beats_clamped;
                        beat_cnt_q <= '0;
                        addr_q     <= bus.ADDR & 32'hFFFF_FFFC;
                        busy_q     <= 1'b1;
                        fcs_n_q    <= 1'b0;
                        ds_n_q     <= 4'hF;
                    end
                end
                ADDR: begin
                    if (!bus.BMASTER) begin
                        state   <= ABORT;
                        busy_q  <= 1'b0;
                        fcs_n_q <= 1'b1;
                        ds_n_q  <= 4'hF;
                        err_q   <= 1'b1;
                    end else begin
                        state  <= DATA;
                        ds_n_q <= ~lanes_q;
                    end
                end
                DATA: begin
                    if (!bus.BMASTER || !bus.ZORRO_BERR_n) begin
                        state   <= ABORT;
                        busy_q  <= 1'b0;
                        fcs_n_q <= 1'b1;
                        ds_n_q  <= 4'hF;
                        err_q   <= 1'b1;
                    end else if (!bus.ZORRO_DTACK_n) begin
                        state      <= TERM;
                        fcs_n_q    <= 1'b1;
                        ds_n_q     <= 4'hF;
                        sterm_n_q  <= 1'b0;
                        beat_cnt_q <= beat_next;
                        done_q     <= (beat_next == total_q);
                    end else if (to_expire) begin
                        state   <= ABORT;
                        busy_q  <= 1'b0;
                        fcs_n_q <= 1'b1;
                        ds_n_q  <= 4'hF;
                        err_q   <= 1'b1;
                    end
                end
                TERM: begin
                    // Losing the grant with beats outstanding truncates the transfer and reports it.
                    if (more_beats && bus.BMASTER) begin
                        state   <= ADDR;
                        addr_q  <= addr_q + 32'd4;
                        lanes_q <= 4'hF;
                        fcs_n_q <= 1'b0;
                        ds_n_q  <= 4'hF;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        err_q  <= more_beats;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.DMA_ADDR     = addr_q;
    assign bus.DMA_FCS_n    = fcs_n_q;
    assign bus.DMA_DS_n     = ds_n_q;
    assign bus.DMA_DOE      = bus.BMASTER & busy_q & ~rd_q;
    assign bus.SCSI_STERM_n = sterm_n_q;
    assign bus.BUSY         = busy_q;
    assign bus.DONE         = done_q;
    assign bus.ERR          = err_q;
    assign bus.BEAT_CNT     = beat_cnt_q;

endmodule
